// File: rtl/pipe_pkg.sv
// Shared pipeline types: forwarding-select encodings and per-stage destination info.
package pipe_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mr;
  } dst_info_t;

endpackage

// File: rtl/reg_match.sv
// Combinational hazard match of one in-flight writer against one ID source; $0 never matches.
module reg_match #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] rd,
  input  logic          rw,
  input  logic [AW-1:0] src,
  input  logic          uses,
  output logic          hit
);

  assign hit = uses && rw && (rd != '0) && (rd == src);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for the 5-stage core.
// FWD_HAZARD_FORWARD_EN enables forwarding; otherwise every RAW hazard stalls.
module fwd_hazard_ctrl #(
  parameter int REG_AW = pipe_pkg::REG_AW,
  parameter int FWD_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [FWD_W-1:0]  forward_a,
  output logic [FWD_W-1:0]  forward_b,
  output logic              stall
);
  import pipe_pkg::*;

  dst_info_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic      ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;

  reg_match #(.AW(REG_AW)) u_ex_rs  (.rd(ex_q.rd),  .rw(ex_q.rw),  .src(id_rs), .uses(id_uses_rs), .hit(ex_hit_rs));
  reg_match #(.AW(REG_AW)) u_ex_rt  (.rd(ex_q.rd),  .rw(ex_q.rw),  .src(id_rt), .uses(id_uses_rt), .hit(ex_hit_rt));
  reg_match #(.AW(REG_AW)) u_mem_rs (.rd(mem_q.rd), .rw(mem_q.rw), .src(id_rs), .uses(id_uses_rs), .hit(mem_hit_rs));
  reg_match #(.AW(REG_AW)) u_mem_rt (.rd(mem_q.rd), .rw(mem_q.rw), .src(id_rt), .uses(id_uses_rt), .hit(mem_hit_rt));

  always_comb begin
    mem_d = ex_q;
    wb_d  = mem_q;
    ex_d  = '{rd: id_rd, rw: id_reg_write, mr: id_mem_read};
    if (reset) begin
      ex_d  = '0;
      mem_d = '0;
      wb_d  = '0;
    end else if (flush || stall) begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    ex_q  <= ex_d;
    mem_q <= mem_d;
    wb_q  <= wb_d;
  end

`ifdef FWD_HAZARD_FORWARD_EN
  logic             ld_hit_rs, ld_hit_rt;
  logic [FWD_W-1:0] forward_a_q, forward_a_d, forward_b_q, forward_b_d;

  // Load-use match keys on the load flag rather than the write-enable.
  reg_match #(.AW(REG_AW)) u_ld_rs (.rd(ex_q.rd), .rw(ex_q.mr), .src(id_rs), .uses(id_uses_rs), .hit(ld_hit_rs));
  reg_match #(.AW(REG_AW)) u_ld_rt (.rd(ex_q.rd), .rw(ex_q.mr), .src(id_rt), .uses(id_uses_rt), .hit(ld_hit_rt));

  assign stall = !flush && (ld_hit_rs || ld_hit_rt);

  always_comb begin
    forward_a_d = FWD_REGFILE;
    forward_b_d = FWD_REGFILE;
    if (!reset && !flush && !stall) begin
      if (ex_hit_rs)       forward_a_d = FWD_EXMEM;
      else if (mem_hit_rs) forward_a_d = FWD_MEMWB;
      if (ex_hit_rt)       forward_b_d = FWD_EXMEM;
      else if (mem_hit_rt) forward_b_d = FWD_MEMWB;
    end
  end

  always_ff @(posedge clk) begin
    forward_a_q <= forward_a_d;
    forward_b_q <= forward_b_d;
  end

  assign forward_a = forward_a_q;
  assign forward_b = forward_b_q;

  logic unused_bits;
  assign unused_bits = ^{mem_q.mr, wb_q};
`else
  assign stall     = !flush && (ex_hit_rs || ex_hit_rt || mem_hit_rs || mem_hit_rt);
  assign forward_a = FWD_REGFILE;
  assign forward_b = FWD_REGFILE;

  // WB writers and load flags carry no hazard information without forwarding.
  logic unused_bits;
  assign unused_bits = ^{ex_q.mr, mem_q.mr, wb_q};
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench for fwd_hazard_ctrl; expectations follow FWD_HAZARD_FORWARD_EN.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, flush;
  logic [1:0] forward_a, forward_b;
  logic       stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(5), .FWD_W(2)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .forward_a(forward_a), .forward_b(forward_b), .stall(stall)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One ID cycle: drive just after the rising edge, return at the falling edge.
  task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                     input logic [4:0] rd, input logic rw, input logic mr,
                     input logic fl, input logic rst);
    @(posedge clk); #1;
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl; reset = rst;
    @(negedge clk);
  endtask

  task automatic alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    cyc(rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ld(input logic [4:0] rs, input logic [4:0] rd);
    cyc(rs, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic nop();
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    id_rs = 5'd3; id_rt = 5'd3; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    id_rd = 5'd3; id_reg_write = 1'b1; id_mem_read = 1'b1;

    // Reset with every input active
    cyc(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    nop();
    chk("rst_fa0", forward_a, 8'h0); chk("rst_fb0", forward_b, 8'h0); chk("rst_st0", stall, 8'h0);
    nop();
    chk("rst_fa1", forward_a, 8'h0); chk("rst_fb1", forward_b, 8'h0); chk("rst_st1", stall, 8'h0);

    // Writer to $0 then a $0 reader
    alu(5'd1, 5'd2, 5'd0);
    alu(5'd0, 5'd0, 5'd9);
    chk("z_alu_st", stall, 8'h0);
    nop();
    chk("z_alu_fa", forward_a, 8'h0); chk("z_alu_fb", forward_b, 8'h0);
    ld(5'd1, 5'd0);
    alu(5'd0, 5'd0, 5'd9);
    chk("z_ld_st", stall, 8'h0);
    nop();
    chk("z_ld_fa", forward_a, 8'h0); chk("z_ld_fb", forward_b, 8'h0);
    nop(); nop();

    // Matching registers that the ID instruction does not read
    alu(5'd1, 5'd2, 5'd3);
    cyc(5'd3, 5'd3, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("nouse_st", stall, 8'h0);
    nop();
    chk("nouse_fa", forward_a, 8'h0); chk("nouse_fb", forward_b, 8'h0);
    nop(); nop();

`ifdef FWD_HAZARD_FORWARD_EN
    // add $3 ; sub ..,$3,$4
    alu(5'd1, 5'd2, 5'd3);
    alu(5'd3, 5'd4, 5'd5);
    chk("exmem_st", stall, 8'h0);
    nop();
    chk("exmem_fa", forward_a, 8'h1); chk("exmem_fb", forward_b, 8'h0);
    nop(); nop();

    // add $3 ; nop ; or ..,$6,$3
    alu(5'd1, 5'd2, 5'd3);
    nop();
    alu(5'd6, 5'd3, 5'd8);
    chk("memwb_st", stall, 8'h0);
    nop();
    chk("memwb_fa", forward_a, 8'h0); chk("memwb_fb", forward_b, 8'h2);
    nop(); nop();

    // Two $3 writers in flight, nearest wins
    alu(5'd1, 5'd2, 5'd3);
    alu(5'd1, 5'd2, 5'd3);
    alu(5'd3, 5'd3, 5'd8);
    nop();
    chk("near_fa", forward_a, 8'h1); chk("near_fb", forward_b, 8'h1);
    nop(); nop();

    // lw $2 ; add ..,$2,$2 : one stall cycle then MEM/WB forward
    ld(5'd1, 5'd2);
    alu(5'd2, 5'd2, 5'd7);
    chk("lu_st1", stall, 8'h1);
    alu(5'd2, 5'd2, 5'd7);
    chk("lu_st2", stall, 8'h0);
    chk("lu_bub_fa", forward_a, 8'h0); chk("lu_bub_fb", forward_b, 8'h0);
    nop();
    chk("lu_fa", forward_a, 8'h2); chk("lu_fb", forward_b, 8'h2);
    nop(); nop();

    // Flush in the stall cycle squashes the consumer
    ld(5'd1, 5'd2);
    cyc(5'd2, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("fl_st", stall, 8'h0);
    cyc(5'd7, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fl_bub_fa", forward_a, 8'h0);
    nop();
    chk("fl_sq_fa", forward_a, 8'h0);
    nop(); nop();

    // Back-to-back loads into $4
    ld(5'd1, 5'd4);
    ld(5'd1, 5'd4);
    chk("bb_st0", stall, 8'h0);
    alu(5'd4, 5'd1, 5'd12);
    chk("bb_st1", stall, 8'h1);
    alu(5'd4, 5'd1, 5'd12);
    chk("bb_st2", stall, 8'h0);
    nop();
    chk("bb_fa", forward_a, 8'h2); chk("bb_fb", forward_b, 8'h0);
    nop(); nop();

    // Reset asserted during the stall cycle
    ld(5'd1, 5'd2);
    cyc(5'd2, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rs_st1", stall, 8'h1);
    alu(5'd2, 5'd2, 5'd7);
    chk("rs_st2", stall, 8'h0);
    nop();
    chk("rs_fa", forward_a, 8'h0); chk("rs_fb", forward_b, 8'h0);
`else
    // add $3 ; sub ..,$3,$4 : two stall cycles, no forwarding
    alu(5'd1, 5'd2, 5'd3);
    alu(5'd3, 5'd4, 5'd5);
    chk("nf_st1", stall, 8'h1);
    alu(5'd3, 5'd4, 5'd5);
    chk("nf_st2", stall, 8'h1);
    chk("nf_fa", forward_a, 8'h0); chk("nf_fb", forward_b, 8'h0);
    alu(5'd3, 5'd4, 5'd5);
    chk("nf_st3", stall, 8'h0);
    nop();
    chk("nf_fa2", forward_a, 8'h0); chk("nf_fb2", forward_b, 8'h0);
    nop(); nop();

    // One instruction apart: single stall
    alu(5'd1, 5'd2, 5'd8);
    nop();
    alu(5'd1, 5'd8, 5'd9);
    chk("gap_st1", stall, 8'h1);
    alu(5'd1, 5'd8, 5'd9);
    chk("gap_st2", stall, 8'h0);
    nop(); nop(); nop();

    // Flush overrides the stall
    alu(5'd1, 5'd2, 5'd3);
    cyc(5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("nfl_st", stall, 8'h0);
    nop(); nop(); nop();

    // Load flag ignored: a load behaves like any writer
    ld(5'd1, 5'd2);
    alu(5'd2, 5'd2, 5'd7);
    chk("nld_st1", stall, 8'h1);
    alu(5'd2, 5'd2, 5'd7);
    chk("nld_st2", stall, 8'h1);
    alu(5'd2, 5'd2, 5'd7);
    chk("nld_st3", stall, 8'h0);
    nop(); nop(); nop();

    // Reset during a stall forgets both in-flight writers
    alu(5'd1, 5'd2, 5'd3);
    cyc(5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("nrs_st1", stall, 8'h1);
    alu(5'd3, 5'd4, 5'd5);
    chk("nrs_st2", stall, 8'h0);
`endif

    nop(); nop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core, between decode and the EX-stage operand muxes. It keeps a shadow copy of the destination, write-enable and load flags for the instructions in EX, MEM and WB. From these it produces registered 2-bit forwarding selects for both EX operands and a combinational load-use stall to the PC, IF/ID and ID/EX registers. Select encoding: 00 = register-file data, 01 = EX/MEM ALU result, 10 = MEM/WB write-back data.

## Interface
Parameters:
- REG_AW, 5, register address width
- FWD_W, 2, forwarding-select width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_rs  in  REG_AW  source register 1 of the instruction in ID
- id_rt  in  REG_AW  source register 2 of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_rd  in  REG_AW  destination of the ID instruction (already muxed rt/rd/31)
- id_reg_write  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- flush  in  1  taken branch/jump; the ID instruction is squashed
- forward_a  out  FWD_W  select for EX operand A
- forward_b  out  FWD_W  select for EX operand B
- stall  out  1  hold PC and IF/ID, insert bubble into EX

## Operation
- The clock is clk and reset is synchronous, active-high, both fixed.
- Shadow state: ex_{rd,rw,mr}, mem_{rd,rw}, wb_{rd,rw}. The shift is unconditional: ex→mem→wb every cycle.
- EX entry rule, in priority order:
  - reset: every shadow register is cleared, including ex_*.
  - flush or stall: a bubble is inserted, ex_rw=0, ex_mr=0, ex_rd=0.
  - otherwise: ex_* takes id_*.
- Hazard match for source s: rw && rd!=0 && rd==s. Register $0 never matches.
- Next forward_a, computed from id_rs and the current state:
  - 01 if id_uses_rs and ex matches (that instruction will be in MEM).
  - else 10 if id_uses_rs and mem matches (it will be in WB).
  - else 00.
  - The EX/MEM match takes priority over MEM/WB.
- forward_b: same rule using id_rt and id_uses_rt.
- forward_a and forward_b are registered and apply to the instruction occupying EX. On a bubble they load 00.
- WB-stage writers are not forwarded. The register file writes in the first half-cycle and reads in the second.
- stall = !flush && ex_mr && ex_rd!=0 && ((id_uses_rs && ex_rd==id_rs) || (id_uses_rt && ex_rd==id_rt)). A load followed by a dependent instruction stalls exactly one cycle, then forwards 10.

## Timing
- Reset values: forward_a=00, forward_b=00, stall=0, all shadow registers 0.
- forward_* latency: one cycle. The selects are valid for the whole cycle the instruction is in EX.
- stall is combinational from id_* and ex_* in the same cycle. There is no feedback path through stall.
- flush and stall together: flush wins. stall reads 0, a bubble is inserted and the ID instruction is discarded.
- reset asserted mid-stall: the stall drops in the next cycle and every in-flight writer is forgotten.
- Back-to-back loads into the same register: each load stalls its own consumer independently.

## Configuration
- FWD_HAZARD_FORWARD_EN defined: forwarding and the load-use stall behave as described above.
- Undefined: forward_a and forward_b are tied to 00.
  - stall = !flush && (ex or mem matches an ID source with rw=1). The load flag is ignored.
  - A dependent instruction right behind its producer stalls 2 cycles; one instruction apart, it stalls 1 cycle.

## Structure
- Shared package `pipe_pkg`:
  - FWD_REGFILE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - REG_AW.
  - Typedef `dst_info_t` {rd, rw, mr}.
- Sub-module `reg_match`: combinational (rd, rw, src, uses) → hit, with the $0 exclusion. It is instantiated once per stage/source pair.

## Test plan
- Reset with every input active → forward_a=forward_b=00 and stall=0 for 2 cycles after reset falls.
- `add $3,..` then `sub ..,$3,$4` → forward_a=01 in the cycle the sub is in EX; forward_b=00.
- `add $3` ; `nop` ; `or ..,$5,$3` → forward_b=10 for the or.
- Both $3-writers in flight (`add $3`,`add $3`,`and ..,$3,$3`) → forward_a=forward_b=01 (the nearest producer wins).
- `lw $2` then `add ..,$2,$2` → stall=1 for exactly 1 cycle, then forward_a=forward_b=10. With flush=1 in the stall cycle → stall=0 and a bubble is inserted.
- Writer to $0 followed by a $0 reader → stall=0, forward_*=00. Repeat the sequence with FWD_HAZARD_FORWARD_EN undefined → the `add $3`;`sub $3` pair gives stall=1 for 2 cycles and forward_*=00.
